cellrv32_pwm_capture: RTL

Pulse-width capture unit: the receive-side counterpart of the PWM controller. It measures period and high time of up to 4 external PWM inputs in prescaled clock ticks and exposes the results as memory-mapped registers on the processor IO bus. The prescaler comes from the shared processor clock generator.

---
 rtl/cellrv32_pwm_capture_if.sv | 21 ++
 rtl/cellrv32_pwm_capture.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_pwm_capture_if.sv
// Processor IO bus as seen by the PWM capture unit.
// The master drives address, strobes and write data; the slave returns
// registered read data and a one-cycle acknowledge.
interface cellrv32_pwm_capture_if;
    logic [31:0] addr_i;
    logic        rden_i;
    logic        wren_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;

    modport master (
        output addr_i, rden_i, wren_i, data_i,
        input  data_o, ack_o
    );

    modport slave (
        input  addr_i, rden_i, wren_i, data_i,
        output data_o, ack_o
    );
endinterface

// File: rtl/cellrv32_pwm_capture.sv
// Pulse-width capture unit: measures period and high time of up to four
// external PWM inputs in prescaled clock ticks and exposes the results as
// read-only registers on the processor IO bus.
module cellrv32_pwm_capture #(
    parameter int unsigned NUM_CHANNELS = 0,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FC00
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    cellrv32_pwm_capture_if.slave  bus,
    output logic                   clkgen_en_o,
    input  logic [7:0]             clkgen_i,
    input  logic [3:0]             pwm_i
);

    localparam logic [31:0] pwmcap_base_c = BASE_ADDR;
    localparam int unsigned pwmcap_size_c = 32;
    localparam int unsigned lo_abb_c      = $clog2(pwmcap_size_c);
    localparam int unsigned hi_abb_c      = 31;

    if (NUM_CHANNELS > 4) begin : g_num_channels_check
        $error("cellrv32_pwm_capture: NUM_CHANNELS must be in 0..4");
    end

    typedef enum logic [1:0] {StIdle, StArmed, StMeas} cap_state_e;

    // Increment by one unless already at the 16-bit ceiling.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    logic        acc_en, rd_sel, wr_sel;
    logic [2:0]  word;
    logic        ctrl_en_q;
    logic [2:0]  ctrl_prsc_q;
    logic        ack_q;
    logic [31:0] rdata_q, rd_mux;
    logic        tick;
    logic [3:0]  rd_ch;
    logic [31:0] ch_data [4];
    logic [3:0]  valid_vec, ovr_vec;
    logic        unused_bits;

    assign acc_en = (bus.addr_i[hi_abb_c:lo_abb_c] == pwmcap_base_c[hi_abb_c:lo_abb_c]);
    assign rd_sel = acc_en & bus.rden_i;
    assign wr_sel = acc_en & bus.wren_i;
    assign word   = bus.addr_i[4:2];
    assign tick   = clkgen_i[ctrl_prsc_q];

    assign bus.ack_o   = ack_q;
    assign bus.data_o  = rdata_q;
    assign clkgen_en_o = ctrl_en_q;

    assign unused_bits = ^{bus.addr_i[1:0], bus.data_i[31:4], pwm_i, tick, rd_ch};

    // Per-channel read strobes; a read of CHn clears its status flags.
    always_comb begin
        rd_ch = '0;
        for (int n = 0; n < 4; n++) begin
            rd_ch[n] = rd_sel && (word == 3'(n + 2));
        end
    end

    // Register read multiplexer.
    always_comb begin
        rd_mux = '0;
        case (word)
            3'd0:    rd_mux = {28'd0, ctrl_prsc_q, ctrl_en_q};
            3'd1:    rd_mux = {20'd0, ovr_vec, 4'd0, valid_vec};
            3'd2:    rd_mux = ch_data[0];
            3'd3:    rd_mux = ch_data[1];
            3'd4:    rd_mux = ch_data[2];
            3'd5:    rd_mux = ch_data[3];
            default: rd_mux = '0;
        endcase
    end

    // Bus response and control register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            ctrl_en_q   <= 1'b0;
            ctrl_prsc_q <= '0;
        end else begin
            ack_q   <= rd_sel | wr_sel;
            rdata_q <= rd_sel ? rd_mux : '0;
            if (wr_sel && (word == 3'd0)) begin
                ctrl_en_q   <= bus.data_i[0];
                ctrl_prsc_q <= bus.data_i[3:1];
            end
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_ch
        if (n < int'(NUM_CHANNELS)) begin : g_impl
            cap_state_e  state_q, state_d;
            logic        s1_q, s2_q, prev_q, rise;
            logic [15:0] per_q, per_d, hi_q, hi_d;
            logic [31:0] ch_q, ch_d;
            logic        valid_q, valid_d, ovr_q, ovr_d;

            assign rise = s2_q & ~prev_q;

            // Synchronizer, edge history and measurement state.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    s1_q    <= 1'b0;
                    s2_q    <= 1'b0;
                    prev_q  <= 1'b0;
                    state_q <= StIdle;
                    per_q   <= '0;
                    hi_q    <= '0;
                    ch_q    <= '0;
                    valid_q <= 1'b0;
                    ovr_q   <= 1'b0;
                end else begin
                    s1_q    <= pwm_i[n];
                    s2_q    <= s1_q;
                    prev_q  <= s2_q;
                    state_q <= state_d;
                    per_q   <= per_d;
                    hi_q    <= hi_d;
                    ch_q    <= ch_d;
                    valid_q <= valid_d;
                    ovr_q   <= ovr_d;
                end
            end

            // Next-state: arm, then latch counters on every rising edge.
            always_comb begin
                state_d = state_q;
                per_d   = per_q;
                hi_d    = hi_q;
                ch_d    = ch_q;
                valid_d = valid_q;
                ovr_d   = ovr_q;
                if (rd_ch[n]) begin
                    valid_d = 1'b0;
                    ovr_d   = 1'b0;
                end
                if (!ctrl_en_q) begin
                    state_d = StIdle;
                    per_d   = '0;
                    hi_d    = '0;
                    ch_d    = '0;
                    valid_d = 1'b0;
                    ovr_d   = 1'b0;
                end else begin
                    unique case (state_q)
                        StIdle: state_d = StArmed;
                        StArmed: begin
                            if (rise) begin
                                state_d = StMeas;
                                per_d   = {15'd0, tick};
                                hi_d    = {15'd0, tick};
                            end
                        end
                        StMeas: begin
                            if (rise) begin
                                ch_d    = {per_q, hi_q};
                                valid_d = 1'b1;
                                // A coincident read leaves the overrun flag as it was.
                                ovr_d   = rd_ch[n] ? ovr_q : (ovr_q | valid_q);
                                per_d   = {15'd0, tick};
                                hi_d    = {15'd0, tick};
                            end else begin
                                per_d = sat_inc(per_q, tick);
                                hi_d  = sat_inc(hi_q, tick & s2_q);
                            end
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end

            assign ch_data[n]   = ch_q;
            assign valid_vec[n] = valid_q;
            assign ovr_vec[n]   = ovr_q;
        end else begin : g_none
            assign ch_data[n]   = '0;
            assign valid_vec[n] = 1'b0;
            assign ovr_vec[n]   = 1'b0;
        end
    end

endmodule
